// File: rtl/wave_dac.sv
// wave_dac: free-running DDS waveform generator (sine/triangle/sawtooth/square) for an 8-bit DAC.
// Optional macro DAC_TWOS_COMP_EN inverts the output MSB for two's-complement DAC coding.
module wave_dac #(
  parameter int unsigned      WAVE      = 0,
  parameter int unsigned      ACC_W     = 16,
  parameter logic [ACC_W-1:0] PHASE_INC = ACC_W'(16'h0100)
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] dac_out
);

`ifdef DAC_TWOS_COMP_EN
  localparam logic [7:0] CodeXor = 8'h80;
`else
  localparam logic [7:0] CodeXor = 8'h00;
`endif
  localparam logic [7:0] ResetCode = 8'h80 ^ CodeXor;

  // Quarter-wave table: round(127*sin(pi*k/128)), k = 0..64.
  localparam logic [6:0] SineQ [65] = '{
    7'd0,   7'd3,   7'd6,   7'd9,   7'd12,  7'd16,  7'd19,  7'd22,
    7'd25,  7'd28,  7'd31,  7'd34,  7'd37,  7'd40,  7'd43,  7'd46,
    7'd49,  7'd51,  7'd54,  7'd57,  7'd60,  7'd63,  7'd65,  7'd68,
    7'd71,  7'd73,  7'd76,  7'd78,  7'd81,  7'd83,  7'd85,  7'd88,
    7'd90,  7'd92,  7'd94,  7'd96,  7'd98,  7'd100, 7'd102, 7'd104,
    7'd106, 7'd107, 7'd109, 7'd111, 7'd112, 7'd113, 7'd115, 7'd116,
    7'd117, 7'd118, 7'd120, 7'd121, 7'd122, 7'd122, 7'd123, 7'd124,
    7'd125, 7'd125, 7'd126, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127,
    7'd127
  };

  logic [ACC_W-1:0] r_phase;
  logic [7:0]       r_dac;
  logic [7:0]       w_idx;
  logic [6:0]       w_k;
  logic [6:0]       w_mag;
  logic [7:0]       w_wave;

  assign w_idx = r_phase[ACC_W-1 -: 8];

  always_comb begin
    // Odd quadrants read the table backwards from entry 64.
    w_k    = w_idx[6] ? (7'd64 - {1'b0, w_idx[5:0]}) : {1'b0, w_idx[5:0]};
    w_mag  = SineQ[w_k];
    w_wave = 8'h80;
    case (WAVE)
      0:       w_wave = w_idx[7] ? (8'd128 - {1'b0, w_mag}) : (8'd128 + {1'b0, w_mag});
      1:       w_wave = w_idx[7] ? {~w_idx[6:0], 1'b1} : {w_idx[6:0], 1'b0};
      2:       w_wave = w_idx;
      3:       w_wave = w_idx[7] ? 8'h00 : 8'hFF;
      default: w_wave = 8'h80;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase <= '0;
      r_dac   <= ResetCode;
    end else begin
      r_phase <= r_phase + PHASE_INC;
      r_dac   <= w_wave ^ CodeXor;
    end
  end

  assign dac_out = r_dac;

endmodule

// File: tb/tb_wave_dac.sv
// Randomized-reset bench for wave_dac: six configurations checked against a real-arithmetic model
// through an expectation queue drained by an independent monitor.
module tb_wave_dac;
  localparam int NInst = 6;

`ifdef DAC_TWOS_COMP_EN
  localparam logic [7:0] Flip = 8'h80;
`else
  localparam logic [7:0] Flip = 8'h00;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NInst-1:0][7:0] dout;

  always #5 clk = ~clk;

  wave_dac #(.WAVE(0), .ACC_W(16), .PHASE_INC(16'h0100)) u_sine (
    .clk(clk), .rst(rst), .dac_out(dout[0]));
  wave_dac #(.WAVE(1), .ACC_W(16), .PHASE_INC(16'h0100)) u_tri (
    .clk(clk), .rst(rst), .dac_out(dout[1]));
  wave_dac #(.WAVE(2), .ACC_W(16), .PHASE_INC(16'h0200)) u_saw (
    .clk(clk), .rst(rst), .dac_out(dout[2]));
  wave_dac #(.WAVE(3), .ACC_W(16), .PHASE_INC(16'h0200)) u_sq (
    .clk(clk), .rst(rst), .dac_out(dout[3]));
  wave_dac #(.WAVE(0), .ACC_W(16), .PHASE_INC(16'h0000)) u_hold (
    .clk(clk), .rst(rst), .dac_out(dout[4]));
  wave_dac #(.WAVE(7), .ACC_W(16), .PHASE_INC(16'h0100)) u_bad (
    .clk(clk), .rst(rst), .dac_out(dout[5]));

  int wave_sel [NInst] = '{0, 1, 2, 3, 0, 7};
  int inc_sel  [NInst] = '{256, 256, 512, 512, 0, 256};

  typedef struct packed {
    int                    n;
    logic [NInst-1:0][7:0] exp;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  int                    m_phase [NInst];
  int                    m_n;
  logic [NInst-1:0][7:0] m_out;

  function automatic logic [7:0] ref_wave(input int w, input int idx);
    real s;
    int  m;
    case (w)
      0: begin
        s = $sin(2.0 * 3.14159265358979 * idx / 256.0);
        m = $rtoi($floor(127.0 * (s < 0.0 ? -s : s) + 0.5));
        return (idx < 128) ? 8'(128 + m) : 8'(128 - m);
      end
      1:       return (idx < 128) ? 8'(2 * idx) : 8'(2 * (255 - idx) + 1);
      2:       return 8'(idx);
      3:       return (idx < 128) ? 8'hFF : 8'h00;
      default: return 8'h80;
    endcase
  endfunction

  function automatic bit spot(input int i, input int n, output logic [7:0] v);
    bit hit = 1'b1;
    v = 8'h00;
    case (i)
      0: case (n)
           1, 129:  v = 8'h80;
           33, 97:  v = 8'hDA;
           65:      v = 8'hFF;
           161:     v = 8'h26;
           193:     v = 8'h01;
           default: hit = 1'b0;
         endcase
      1: case (n)
           1, 257:  v = 8'h00;
           128:     v = 8'hFE;
           129:     v = 8'hFF;
           256:     v = 8'h01;
           default: hit = 1'b0;
         endcase
      2: case (n)
           1, 129:  v = 8'h00;
           2:       v = 8'h02;
           3:       v = 8'h04;
           4:       v = 8'h06;
           default: hit = 1'b0;
         endcase
      3: case (n)
           1, 64, 129: v = 8'hFF;
           65, 128:    v = 8'h00;
           default:    hit = 1'b0;
         endcase
      4, 5: case (n)
           1, 200, 300: v = 8'h80;
           default:     hit = 1'b0;
         endcase
      default: hit = 1'b0;
    endcase
    v = v ^ Flip;
    return hit;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NInst; i++) begin
      m_phase[i] = 0;
      m_out[i]   = 8'h80 ^ Flip;
    end
    m_n = 0;
  endtask

  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else begin
      for (int i = 0; i < NInst; i++) begin
        m_out[i]   = ref_wave(wave_sel[i], m_phase[i] / 256) ^ Flip;
        m_phase[i] = (m_phase[i] + inc_sel[i]) % 65536;
      end
      m_n++;
    end
  endtask

  // One clock: model the edge, optionally release or asynchronously assert rst, queue expectation.
  task automatic tick(input bit do_assert, input bit do_release);
    exp_t e;
    int   d;
    @(posedge clk);
    model_edge();
    #1;
    if (do_release) rst = 1'b0;
    if (do_assert) begin
      d = $urandom_range(0, 2);
      #(d);
      rst = 1'b1;
      model_reset();
    end
    e.n   = m_n;
    e.exp = m_out;
    q.push_back(e);
  endtask

  task automatic check(input string name, input int i, input int n, input logic [7:0] act,
                       input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s inst%0d edge=%0d got=%h expected=%h", name, i, n, act, req);
    end
  endtask

  // Monitor: consume one queued expectation per cycle, between active edges.
  initial begin
    exp_t       e;
    logic [7:0] v;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        for (int i = 0; i < NInst; i++) begin
          check("model", i, e.n, dout[i], e.exp[i]);
          if (e.n > 0 && spot(i, e.n, v)) check("spot", i, e.n, dout[i], v);
        end
      end
    end
  end

  initial begin
    int hold;
    model_reset();
    rst = 1'b1;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    repeat (300) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    hold = $urandom_range(0, 2);
    repeat (hold) tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    repeat (49) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b1);
    repeat (700) tick(1'b0, 1'b0);
    repeat (3) begin
      hold = $urandom_range(5, 150);
      repeat (hold) tick(1'b0, 1'b0);
      tick(1'b1, 1'b0);
      hold = $urandom_range(0, 2);
      repeat (hold) tick(1'b0, 1'b0);
      tick(1'b0, 1'b1);
    end
    repeat (20) tick(1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
